// File: rtl/single_sorter.sv
// Batch sorter for IEEE-754 single-precision words: load up to DEPTH words,
// bubble-sort them with one shared comparator, then stream them out in order.
module single_sorter #(
  parameter int DEPTH      = 8,
  parameter bit DESCENDING = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);

  localparam int NW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_r;
  logic [NW-1:0] n_r;
  logic [IW-1:0] i_r;
  logic [IW-1:0] k_r;
  logic          swapped_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [31:0]   mem_r [DEPTH];

  logic [31:0]   cmp_a_s;
  logic [31:0]   cmp_b_s;
  logic          swap_s;
  logic          accept_s;
  logic          load_done_s;
  logic          pass_end_s;
  logic          drain_fire_s;
  logic          drain_last_s;

  // Signed-magnitude ordering; +0 and -0 compare equal so they never swap.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic r;
    if (a[31] != b[31]) begin
      r = ~a[31] & ~((a[30:0] == 31'd0) & (b[30:0] == 31'd0));
    end else if (a[31] == 1'b0) begin
      r = (a[30:0] > b[30:0]);
    end else begin
      r = (b[30:0] > a[30:0]);
    end
    return r;
  endfunction

  // Shared comparator and handshake decode.
  always_comb begin
    cmp_a_s      = mem_r[i_r];
    cmp_b_s      = mem_r[IW'(i_r + IW'(1))];
    swap_s       = (state_r == SORT) &
                   (DESCENDING ? fp_gt(cmp_b_s, cmp_a_s) : fp_gt(cmp_a_s, cmp_b_s));
    accept_s     = in_ready_r & in_valid;
    load_done_s  = accept_s & (in_last | (n_r == NW'(DEPTH - 1)));
    pass_end_s   = (i_r == IW'(n_r - NW'(2)));
    drain_fire_s = out_valid_r & out_ready;
    drain_last_s = (k_r == IW'(n_r - NW'(1)));
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_valid_r ? mem_r[k_r] : 32'd0;
  assign out_last  = out_valid_r & drain_last_s;
  assign busy      = (state_r != LOAD) | (n_r != NW'(0));

  // Control FSM: LOAD -> SORT (n>=2) or DRAIN (n==1) -> LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LOAD;
      n_r         <= NW'(0);
      i_r         <= IW'(0);
      k_r         <= IW'(0);
      swapped_r   <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            n_r <= n_r + NW'(1);
          end
          if (load_done_s) begin
            in_ready_r <= 1'b0;
            i_r        <= IW'(0);
            swapped_r  <= 1'b0;
            if (n_r != NW'(0)) begin
              state_r <= SORT;
            end else begin
              state_r     <= DRAIN;
              out_valid_r <= 1'b1;
              k_r         <= IW'(0);
            end
          end
        end
        SORT: begin
          if (pass_end_s) begin
            if (swapped_r | swap_s) begin
              swapped_r <= 1'b0;
              i_r       <= IW'(0);
            end else begin
              state_r     <= DRAIN;
              out_valid_r <= 1'b1;
              k_r         <= IW'(0);
            end
          end else begin
            i_r       <= i_r + IW'(1);
            swapped_r <= swapped_r | swap_s;
          end
        end
        DRAIN: begin
          if (drain_fire_s) begin
            if (drain_last_s) begin
              state_r     <= LOAD;
              n_r         <= NW'(0);
              k_r         <= IW'(0);
              out_valid_r <= 1'b0;
              in_ready_r  <= 1'b1;
            end else begin
              k_r <= k_r + IW'(1);
            end
          end
        end
        default: begin
          state_r     <= LOAD;
          n_r         <= NW'(0);
          i_r         <= IW'(0);
          k_r         <= IW'(0);
          swapped_r   <= 1'b0;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Word storage: written on accept, pair-swapped during SORT; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[IW'(n_r)] <= in_data;
    end else if (swap_s) begin
      mem_r[i_r]                <= cmp_b_s;
      mem_r[IW'(i_r + IW'(1))] <= cmp_a_s;
    end
  end

endmodule

// File: tb/tb_single_sorter.sv
// Directed bench for single_sorter: instance 0 ascending, instance 1 descending.
module tb_single_sorter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0][31:0] in_data;
  logic [1:0]       in_last;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0][31:0] out_data;
  logic [1:0]       out_last;
  logic [1:0]       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  single_sorter #(.DEPTH(8), .DESCENDING(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .busy(busy[0])
  );

  single_sorter #(.DEPTH(8), .DESCENDING(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input int u, input logic [31:0] d, input logic last);
    check("in_ready_load", 32'(in_ready[u]), 32'd1);
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    in_last[u]  = last;
    @(negedge clk);
    in_valid[u] = 1'b0;
    in_last[u]  = 1'b0;
  endtask

  task automatic wait_out(input int u, input int exp_cycles, input string tag);
    int cnt = 0;
    while (out_valid[u] !== 1'b1 && cnt < 300) begin
      check("in_ready_sort", 32'(in_ready[u]), 32'd0);
      @(negedge clk);
      cnt++;
    end
    check(tag, 32'(cnt), 32'(exp_cycles));
  endtask

  task automatic recv(input int u, input logic [31:0] d, input logic last, input logic stall);
    check("out_valid", 32'(out_valid[u]), 32'd1);
    check("out_data", out_data[u], d);
    check("out_last", 32'(out_last[u]), 32'(last));
    check("in_ready_drain", 32'(in_ready[u]), 32'd0);
    if (stall) begin
      out_ready[u] = 1'b0;
      @(negedge clk);
      check("hold_valid", 32'(out_valid[u]), 32'd1);
      check("hold_data", out_data[u], d);
    end
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
  endtask

  task automatic idle_check(input int u);
    check("idle_out_valid", 32'(out_valid[u]), 32'd0);
    check("idle_in_ready", 32'(in_ready[u]), 32'd1);
    check("idle_busy", 32'(busy[u]), 32'd0);
  endtask

  logic [31:0] asc8 [8];
  logic [31:0] mix8 [8];

  initial begin
    asc8 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    mix8 = '{32'h41000000, 32'h40400000, 32'h3F800000, 32'h00000000,
             32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC1000000};
    rst_n     = 1'b0;
    in_valid  = 2'b00;
    in_last   = 2'b00;
    in_data   = '{32'd0, 32'd0};
    out_ready = 2'b00;
    #1;
    check("rst_in_ready", 32'(in_ready[0]), 32'd0);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_out_last", 32'(out_last[0]), 32'd0);
    check("rst_out_data", out_data[0], 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_check(0);
    idle_check(1);

    // Mixed-sign 4-word batch.
    send(0, 32'h40400000, 1'b0);
    send(0, 32'hBF800000, 1'b0);
    send(0, 32'h3F000000, 1'b0);
    send(0, 32'h40000000, 1'b1);
    wait_out(0, 6, "sort_cycles_4w");
    recv(0, 32'hBF800000, 1'b0, 1'b0);
    recv(0, 32'h3F000000, 1'b0, 1'b0);
    recv(0, 32'h40000000, 1'b0, 1'b0);
    recv(0, 32'h40400000, 1'b1, 1'b0);
    idle_check(0);

    // Full batch of ascending words with no in_last.
    for (int j = 0; j < 8; j++) send(0, asc8[j], 1'b0);
    check("in_ready_full", 32'(in_ready[0]), 32'd0);
    wait_out(0, 7, "sort_cycles_sorted8");
    for (int j = 0; j < 8; j++) recv(0, asc8[j], (j == 7), 1'b0);
    idle_check(0);

    // +0 then -0: equal, no swap in either order.
    send(0, 32'h00000000, 1'b0);
    send(0, 32'h80000000, 1'b1);
    wait_out(0, 1, "sort_cycles_zero_asc");
    recv(0, 32'h00000000, 1'b0, 1'b0);
    recv(0, 32'h80000000, 1'b1, 1'b0);
    idle_check(0);
    send(1, 32'h00000000, 1'b0);
    send(1, 32'h80000000, 1'b1);
    wait_out(1, 1, "sort_cycles_zero_desc");
    recv(1, 32'h00000000, 1'b0, 1'b0);
    recv(1, 32'h80000000, 1'b1, 1'b0);
    idle_check(1);

    // Descending instance reorders a rising pair.
    send(1, 32'h3F800000, 1'b0);
    send(1, 32'h40000000, 1'b1);
    wait_out(1, 2, "sort_cycles_desc_pair");
    recv(1, 32'h40000000, 1'b0, 1'b0);
    recv(1, 32'h3F800000, 1'b1, 1'b0);
    idle_check(1);

    // Reverse-ordered batch, worst case, with out_ready toggling.
    for (int j = 0; j < 8; j++) send(0, mix8[j], 1'b0);
    wait_out(0, 56, "sort_cycles_worst");
    for (int j = 0; j < 8; j++) recv(0, mix8[7 - j], (j == 7), 1'b1);
    idle_check(0);

    // Single word goes straight to DRAIN.
    send(0, 32'hC2C80000, 1'b1);
    wait_out(0, 0, "sort_cycles_single");
    recv(0, 32'hC2C80000, 1'b1, 1'b0);
    idle_check(0);

    // Reset in the 3rd SORT cycle discards the batch.
    send(0, 32'h40400000, 1'b0);
    send(0, 32'h40000000, 1'b0);
    send(0, 32'h3F800000, 1'b1);
    repeat (2) @(negedge clk);
    check("pre_rst_out_valid", 32'(out_valid[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready[0]), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_out_data", out_data[0], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("release_in_ready", 32'(in_ready[0]), 32'd0);
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready[0]), 32'd1);
    for (int j = 0; j < 5; j++) begin
      check("post_rst_out_valid", 32'(out_valid[0]), 32'd0);
      @(negedge clk);
    end
    idle_check(0);
    send(0, 32'h40000000, 1'b0);
    send(0, 32'h3F800000, 1'b1);
    wait_out(0, 2, "sort_cycles_post_rst");
    recv(0, 32'h3F800000, 1'b0, 1'b0);
    recv(0, 32'h40000000, 1'b1, 1'b0);
    idle_check(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
